lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have ports i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have ports i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have ports i_req, input, 1 bit: core access request; i_we input 1 (1=store); i_addr input 32 (byte address); i_wdata input 32 (store data, right-justified).
REQ-004 SHALL have ports i_size, input, 2 bits: 00=byte, 01=half, 10=word, 11 treated as word; i_unsigned input 1 (zero-extend loads, ignored for word and stores).
REQ-005 SHALL have ports o_ready, output, 1 bit: controller idle and accepting; o_rsp_valid output 1: access complete; o_rdata output 32: extended load result.
REQ-006 SHALL have memory-side ports o_mem_req output 1, o_mem_we output 1, o_mem_addr output 32 (word-aligned, bits[1:0]=00), o_mem_wdata output 32, o_mem_be output 4, i_mem_ack input 1, i_mem_rdata input 32.

Function
REQ-007 SHALL implement FSM states IDLE, ACC0, ACC1, RESP.
REQ-008 IDLE: o_ready=1; on i_req=1 at a clock edge SHALL register we/addr/wdata/size/unsigned and move to ACC0.
REQ-009 i_req while o_ready=0 SHALL be ignored; requester holds i_req until accepted.
REQ-010 Split access SHALL occur when addr[1:0]+bytes(size) > 4 (half at offset 3; word at offset 1..3).
REQ-011 ACC0: o_mem_req=1, o_mem_addr={addr[31:2],2'b00}, o_mem_be=(mask(size)<<addr[1:0])[3:0], o_mem_wdata=wdata<<(8*addr[1:0]).
REQ-012 ACC1: o_mem_req=1, o_mem_addr={addr[31:2],2'b00}+4, o_mem_be=mask(size)>>(4-addr[1:0]), o_mem_wdata=wdata>>(32-8*addr[1:0]).
REQ-013 mask(size) SHALL be 0001 byte, 0011 half, 1111 word.
REQ-014 o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata SHALL be stable while o_mem_req=1 and i_mem_ack=0 (unbounded wait states).
REQ-015 i_mem_ack sampled high in ACC0 SHALL capture i_mem_rdata as low word and go to ACC1 if split, else RESP.
REQ-016 i_mem_ack sampled high in ACC1 SHALL capture i_mem_rdata as high word and go to RESP.
REQ-017 i_mem_ack outside ACC0/ACC1 SHALL be ignored.
REQ-018 Load result: take {high,low}>>(8*addr[1:0]), keep low 8/16/32 bits per size, sign-extend from the top kept bit unless i_unsigned=1 (then zero-extend).
REQ-019 RESP: o_rsp_valid=1 for exactly one cycle, o_rdata=registered load result (0x00000000 for stores), then IDLE.
REQ-020 o_rdata SHALL hold its value until the next RESP.
REQ-021 Minimum latency: accept at edge N, ack in cycle N+1, o_rsp_valid in cycle N+2; split with zero waits: o_rsp_valid in cycle N+3.
REQ-022 Outside ACC0/ACC1: o_mem_req=0 and o_mem_be=0000.
REQ-023 o_mem_we SHALL equal the registered we during ACC0/ACC1.
REQ-024 Back-to-back: o_ready SHALL return to 1 the cycle after RESP; no request accepted during RESP.

Reset
REQ-025 i_rst_n=0 SHALL immediately force IDLE, o_ready=1, o_rsp_valid=0, o_rdata=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_be=0, o_mem_wdata=0.
REQ-026 Reset during ACC0/ACC1 SHALL abort the access with no response; a later ack SHALL be ignored.

Verification
REQ-027 lb at 0x1003, ack 0 waits, rdata 0x80123456 -> one access, be=1000, o_rdata=0xFFFFFF80, rsp_valid at N+2.
REQ-028 lhu at 0x1003, rdata 0xAB000000 then 0x000000CD -> addrs 0x1000/0x1004, be 1000/0001, o_rdata=0x0000CDAB.
REQ-029 sw 0x11223344 at 0x1001 -> access 1: addr 0x1000, be=1110, wdata=0x22334400; access 2: addr 0x1004, be=0001, wdata=0x00000011; o_rdata=0.
REQ-030 lw at 0x2000, ack after 3 wait cycles -> mem outputs stable 4 cycles, o_rdata=i_mem_rdata, rsp_valid 1 cycle.
REQ-031 lh at 0x2002, rdata 0x8001xxxx -> be=1100, o_rdata=0xFFFF8001; same with i_unsigned=1 -> 0x00008001.
REQ-032 i_rst_n low during ACC1 of a split lw -> o_mem_req=0 immediately, no o_rsp_valid, o_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the core-side request/response signals and the memory-side bus
// of the load/store unit memory controller.
//   Core side   : i_req, i_we, i_addr, i_wdata, i_size, i_unsigned -> controller
//                 o_ready, o_rsp_valid, o_rdata                     <- controller
//   Memory side : o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be <- controller
//                 i_mem_ack, i_mem_rdata                                 -> controller
// modport slave  : the controller's view.
// modport master : the environment's view (core requester + memory).
interface lsu_mem_ctrl_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        o_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
    output o_ready, o_rsp_valid, o_rdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_size, i_unsigned, i_mem_ack, i_mem_rdata,
    input  o_ready, o_rsp_valid, o_rdata,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller. Accepts one byte/half/word access from
// the core, turns it into one or two word-aligned memory bus accesses (two
// when the access crosses a word boundary), and returns a sign- or
// zero-extended load result with a single-cycle response pulse.
// Ports:
//   i_clk   : clock, rising edge.
//   i_rst_n : asynchronous active-low reset.
//   bus     : lsu_mem_ctrl_if.slave -- core request/response and memory bus.
module lsu_mem_ctrl (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lsu_mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state_q, state_d;

  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic [31:0] rdata_q;

  logic        split;
  logic [7:0]  be_wide;
  logic [3:0]  be_acc0;
  logic [3:0]  be_acc1;
  logic [31:0] wdata_acc0;
  logic [31:0] wdata_acc1;
  logic        fin;
  logic [63:0] fin_pair;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Align the {high,low} word pair down to the addressed byte, then extend
  // the kept 8/16/32 bits.
  function automatic logic [31:0] load_extend(input logic [63:0] pair,
                                              input logic [1:0]  off,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    logic        [31:0] w;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    w = pair[{off, 3'b000} +: 32];
    b = w[7:0];
    h = w[15:0];
    case (sz)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign split      = ({1'b0, addr_q[1:0]} + size_bytes(size_q)) > 3'd4;
  assign be_wide    = {4'b0000, size_mask(size_q)} << addr_q[1:0];
  assign be_acc0    = be_wide[3:0];
  assign be_acc1    = size_mask(size_q) >> (3'd4 - {1'b0, addr_q[1:0]});
  assign wdata_acc0 = wdata_q << {addr_q[1:0], 3'b000};
  assign wdata_acc1 = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});

  // ---- state register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---- next state and bus outputs ----
  always_comb begin
    state_d         = state_q;
    bus.o_ready     = 1'b0;
    bus.o_rsp_valid = 1'b0;
    bus.o_mem_req   = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = 32'h0;
    bus.o_mem_be    = 4'b0000;
    bus.o_mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_req) state_d = ACC0;
      end
      ACC0: begin
        bus.o_mem_req   = 1'b1;
        bus.o_mem_we    = we_q;
        bus.o_mem_addr  = {addr_q[31:2], 2'b00};
        bus.o_mem_be    = be_acc0;
        bus.o_mem_wdata = wdata_acc0;
        if (bus.i_mem_ack) state_d = split ? ACC1 : RESP;
      end
      ACC1: begin
        bus.o_mem_req   = 1'b1;
        bus.o_mem_we    = we_q;
        bus.o_mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
        bus.o_mem_be    = be_acc1;
        bus.o_mem_wdata = wdata_acc1;
        if (bus.i_mem_ack) state_d = RESP;
      end
      RESP: begin
        bus.o_rsp_valid = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Final ack of the access: assemble the word pair seen on the bus.
  always_comb begin
    fin      = 1'b0;
    fin_pair = 64'h0;
    if (state_q == ACC0 && bus.i_mem_ack && !split) begin
      fin      = 1'b1;
      fin_pair = {32'h0, bus.i_mem_rdata};
    end else if (state_q == ACC1 && bus.i_mem_ack) begin
      fin      = 1'b1;
      fin_pair = {bus.i_mem_rdata, lo_q};
    end
  end

  // ---- request capture and low-word capture ----
  // Only qualified by state, so these hold no reset; the bus outputs are
  // gated to zero whenever they are not in use.
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && bus.i_req) begin
      we_q    <= bus.i_we;
      addr_q  <= bus.i_addr;
      wdata_q <= bus.i_wdata;
      size_q  <= bus.i_size;
      uns_q   <= bus.i_unsigned;
    end
    if (state_q == ACC0 && bus.i_mem_ack) lo_q <= bus.i_mem_rdata;
  end

  // ---- response data ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  rdata_q <= 32'h0;
    else if (fin)  rdata_q <= we_q ? 32'h0
                                   : load_extend(fin_pair, addr_q[1:0], size_q, uns_q);
  end

  assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic i_clk;
  logic i_rst_n;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mem_t;

  mem_t        exp_mem[$];
  mem_t        obs_mem[$];
  logic [31:0] exp_rsp[$];
  int          exp_lat[$];
  int          obs_acc_cycles[$];

  logic [31:0] obs_rdata;
  logic [31:0] rdata_after;
  int          obs_lat;
  int          obs_rsp_cnt;
  bit          obs_stable;
  logic        ready_after;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Drives one request, plays the memory (waits wait states per access) and
  // records what the DUT did; the calling test does all comparisons.
  task automatic run_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size,
                            input logic uns, input int waits,
                            input logic [31:0] rd0, input logic [31:0] rd1,
                            input bit hold);
    int   t, cyc, w, acc;
    bit   done;
    mem_t snap, cur;
    obs_mem.delete();
    obs_acc_cycles.delete();
    obs_stable  = 1'b1;
    obs_rsp_cnt = 0;
    obs_lat     = -1;
    obs_rdata   = 32'hx;
    rdata_after = 32'hx;
    ready_after = 1'b0;
    snap        = '0;
    t = 0;
    while (bus.o_ready !== 1'b1 && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    bus.i_req      = 1'b1;
    bus.i_we       = we;
    bus.i_addr     = addr;
    bus.i_wdata    = wdata;
    bus.i_size     = size;
    bus.i_unsigned = uns;
    @(posedge i_clk);
    #1;
    if (!hold) bus.i_req = 1'b0;
    cyc  = 0;
    w    = 0;
    acc  = 0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = $urandom;
      if (obs_rsp_cnt > 0 && cyc == obs_lat + 1) begin
        ready_after = bus.o_ready;
        rdata_after = bus.o_rdata;
        if (bus.o_rsp_valid === 1'b1) obs_rsp_cnt++;
        done = 1'b1;
      end else begin
        if (bus.o_rsp_valid === 1'b1) begin
          obs_rsp_cnt++;
          obs_lat   = cyc;
          obs_rdata = bus.o_rdata;
        end
        if (bus.o_mem_req === 1'b1) begin
          cur = {bus.o_mem_addr, bus.o_mem_be, bus.o_mem_we, bus.o_mem_wdata};
          if (w == 0) snap = cur;
          else if (cur !== snap) obs_stable = 1'b0;
          if (w == waits) begin
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = (acc == 0) ? rd0 : rd1;
            obs_mem.push_back(cur);
            obs_acc_cycles.push_back(w + 1);
            acc++;
            w = 0;
          end else begin
            w++;
          end
        end
      end
    end
    bus.i_req     = 1'b0;
    bus.i_mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    check_cnt++;
    if (bus.o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.o_ready);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.o_rsp_valid);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", bus.o_rdata);
    else pass_cnt++;
    check_cnt++;
    if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_be} !== 6'b0)
      $display("FAIL reset_mem_ctl: got req=%b we=%b be=%b want 0/0/0000",
               bus.o_mem_req, bus.o_mem_we, bus.o_mem_be);
    else pass_cnt++;
    check_cnt++;
    if ({bus.o_mem_addr, bus.o_mem_wdata} !== 64'h0)
      $display("FAIL reset_mem_data: got addr=%h wdata=%h want 0/0", bus.o_mem_addr, bus.o_mem_wdata);
    else pass_cnt++;
  endtask

  // Pops the scoreboard for one access and compares against what was recorded.
  // Kept inline in each test via this sequence of statements.
  task automatic test_lb_high_byte;
    mem_t e, o;
    logic [31:0] er;
    int el;
    exp_mem.push_back({32'h0000_1000, 4'b1000, 1'b0, 32'h0});
    exp_rsp.push_back(32'hFFFF_FF80);
    exp_lat.push_back(2);
    run_access(1'b0, 32'h0000_1003, 32'h0, 2'b00, 1'b0, 0, 32'h8012_3456, 32'h0, 1'b0);
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
      check_cnt++;
      if (o !== e) $display("FAIL lb_mem: got %h want %h", o, e);
      else pass_cnt++;
    end
    check_cnt++;
    if (obs_mem.size() !== 0) $display("FAIL lb_extra_acc: got %0d extra want 0", obs_mem.size());
    else pass_cnt++;
    er = exp_rsp.pop_front();
    el = exp_lat.pop_front();
    check_cnt++;
    if (obs_rsp_cnt !== 1) $display("FAIL lb_rsp_cnt: got %0d want 1", obs_rsp_cnt);
    else pass_cnt++;
    check_cnt++;
    if (obs_rdata !== er) $display("FAIL lb_rdata: got %h want %h", obs_rdata, er);
    else pass_cnt++;
    check_cnt++;
    if (obs_lat !== el) $display("FAIL lb_latency: got %0d want %0d", obs_lat, el);
    else pass_cnt++;
  endtask

  task automatic test_lhu_split;
    mem_t e, o;
    logic [31:0] er;
    int el;
    exp_mem.push_back({32'h0000_1000, 4'b1000, 1'b0, 32'h0});
    exp_mem.push_back({32'h0000_1004, 4'b0001, 1'b0, 32'h0});
    exp_rsp.push_back(32'h0000_CDAB);
    exp_lat.push_back(3);
    run_access(1'b0, 32'h0000_1003, 32'h0, 2'b01, 1'b1, 0, 32'hAB00_0000, 32'h0000_00CD, 1'b0);
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
      check_cnt++;
      if (o !== e) $display("FAIL lhu_mem: got %h want %h", o, e);
      else pass_cnt++;
    end
    check_cnt++;
    if (obs_mem.size() !== 0) $display("FAIL lhu_extra_acc: got %0d extra want 0", obs_mem.size());
    else pass_cnt++;
    er = exp_rsp.pop_front();
    el = exp_lat.pop_front();
    check_cnt++;
    if (obs_rdata !== er) $display("FAIL lhu_rdata: got %h want %h", obs_rdata, er);
    else pass_cnt++;
    check_cnt++;
    if (obs_lat !== el) $display("FAIL lhu_latency: got %0d want %0d", obs_lat, el);
    else pass_cnt++;
  endtask

  task automatic test_sw_split;
    mem_t e, o;
    logic [31:0] er;
    int el;
    exp_mem.push_back({32'h0000_1000, 4'b1110, 1'b1, 32'h2233_4400});
    exp_mem.push_back({32'h0000_1004, 4'b0001, 1'b1, 32'h0000_0011});
    exp_rsp.push_back(32'h0);
    exp_lat.push_back(3);
    run_access(1'b1, 32'h0000_1001, 32'h1122_3344, 2'b10, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
      check_cnt++;
      if (o !== e) $display("FAIL sw_mem: got %h want %h", o, e);
      else pass_cnt++;
    end
    check_cnt++;
    if (obs_mem.size() !== 0) $display("FAIL sw_extra_acc: got %0d extra want 0", obs_mem.size());
    else pass_cnt++;
    er = exp_rsp.pop_front();
    el = exp_lat.pop_front();
    check_cnt++;
    if (obs_rdata !== er) $display("FAIL sw_rdata: got %h want %h", obs_rdata, er);
    else pass_cnt++;
    check_cnt++;
    if (obs_lat !== el) $display("FAIL sw_latency: got %0d want %0d", obs_lat, el);
    else pass_cnt++;
  endtask

  task automatic test_lw_wait;
    mem_t e, o;
    logic [31:0] er;
    int el, ac;
    exp_mem.push_back({32'h0000_2000, 4'b1111, 1'b0, 32'h0});
    exp_rsp.push_back(32'hDEAD_BEEF);
    exp_lat.push_back(5);
    run_access(1'b0, 32'h0000_2000, 32'h0, 2'b10, 1'b0, 3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    while (exp_mem.size() > 0) begin
      e = exp_mem.pop_front();
      o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
      check_cnt++;
      if (o !== e) $display("FAIL lw_mem: got %h want %h", o, e);
      else pass_cnt++;
    end
    ac = (obs_acc_cycles.size() > 0) ? obs_acc_cycles.pop_front() : 0;
    check_cnt++;
    if (ac !== 4) $display("FAIL lw_req_cycles: got %0d want 4", ac);
    else pass_cnt++;
    check_cnt++;
    if (obs_stable !== 1'b1) $display("FAIL lw_stable: got %b want 1", obs_stable);
    else pass_cnt++;
    er = exp_rsp.pop_front();
    el = exp_lat.pop_front();
    check_cnt++;
    if (obs_rdata !== er) $display("FAIL lw_rdata: got %h want %h", obs_rdata, er);
    else pass_cnt++;
    check_cnt++;
    if (obs_lat !== el) $display("FAIL lw_latency: got %0d want %0d", obs_lat, el);
    else pass_cnt++;
    check_cnt++;
    if (obs_rsp_cnt !== 1) $display("FAIL lw_rsp_cnt: got %0d want 1", obs_rsp_cnt);
    else pass_cnt++;
    check_cnt++;
    if (rdata_after !== er) $display("FAIL lw_rdata_hold: got %h want %h", rdata_after, er);
    else pass_cnt++;
  endtask

  task automatic test_lh_sign;
    mem_t e, o;
    logic [31:0] er;
    for (int u = 0; u < 2; u++) begin
      exp_mem.push_back({32'h0000_2000, 4'b1100, 1'b0, 32'h0});
      exp_rsp.push_back((u == 0) ? 32'hFFFF_8001 : 32'h0000_8001);
      run_access(1'b0, 32'h0000_2002, 32'h0, 2'b01, u[0], 0, 32'h8001_5A5A, 32'h0, 1'b0);
      e = exp_mem.pop_front();
      o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
      check_cnt++;
      if (o !== e) $display("FAIL lh_mem u=%0d: got %h want %h", u, o, e);
      else pass_cnt++;
      er = exp_rsp.pop_front();
      check_cnt++;
      if (obs_rdata !== er) $display("FAIL lh_rdata u=%0d: got %h want %h", u, obs_rdata, er);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    mem_t e, o;
    logic [31:0] er;
    // First request held on i_req through the whole access and its response.
    exp_mem.push_back({32'h0000_3000, 4'b0100, 1'b1, 32'h00AB_0000});
    exp_rsp.push_back(32'h0);
    run_access(1'b1, 32'h0000_3002, 32'h0000_00AB, 2'b00, 1'b0, 1, 32'h0, 32'h0, 1'b1);
    e = exp_mem.pop_front();
    o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
    check_cnt++;
    if (o !== e) $display("FAIL b2b_sb_mem: got %h want %h", o, e);
    else pass_cnt++;
    check_cnt++;
    if (obs_mem.size() !== 0) $display("FAIL b2b_extra_acc: got %0d extra want 0", obs_mem.size());
    else pass_cnt++;
    er = exp_rsp.pop_front();
    check_cnt++;
    if (obs_rdata !== er) $display("FAIL b2b_sb_rdata: got %h want %h", obs_rdata, er);
    else pass_cnt++;
    check_cnt++;
    if (ready_after !== 1'b1) $display("FAIL b2b_ready_after_resp: got %b want 1", ready_after);
    else pass_cnt++;
    check_cnt++;
    if (obs_rsp_cnt !== 1) $display("FAIL b2b_rsp_cnt: got %0d want 1", obs_rsp_cnt);
    else pass_cnt++;
    // Size 11 behaves as a word access; issued immediately.
    exp_mem.push_back({32'h0000_3000, 4'b1111, 1'b0, 32'h0});
    exp_rsp.push_back(32'h1234_5678);
    exp_lat.push_back(2);
    run_access(1'b0, 32'h0000_3000, 32'h0, 2'b11, 1'b1, 0, 32'h1234_5678, 32'h0, 1'b0);
    e = exp_mem.pop_front();
    o = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
    check_cnt++;
    if (o !== e) $display("FAIL b2b_lw_mem: got %h want %h", o, e);
    else pass_cnt++;
    er = exp_rsp.pop_front();
    check_cnt++;
    if (obs_rdata !== er) $display("FAIL b2b_lw_rdata: got %h want %h", obs_rdata, er);
    else pass_cnt++;
    check_cnt++;
    if (obs_lat !== exp_lat[0]) $display("FAIL b2b_lw_latency: got %0d want %0d", obs_lat, exp_lat[0]);
    else pass_cnt++;
    exp_lat.delete();
  endtask

  task automatic test_reset_acc1;
    int  t;
    bit  bad;
    t = 0;
    while (bus.o_ready !== 1'b1 && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    bus.i_req      = 1'b1;
    bus.i_we       = 1'b0;
    bus.i_addr     = 32'h0000_4001;
    bus.i_wdata    = 32'h0;
    bus.i_size     = 2'b10;
    bus.i_unsigned = 1'b0;
    @(posedge i_clk);
    #1;
    bus.i_req = 1'b0;
    @(negedge i_clk);
    check_cnt++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h0000_4000)
      $display("FAIL rst_acc0: got req=%b addr=%h want 1/00004000", bus.o_mem_req, bus.o_mem_addr);
    else pass_cnt++;
    bus.i_mem_ack   = 1'b1;
    bus.i_mem_rdata = 32'h5555_AAAA;
    @(negedge i_clk);
    bus.i_mem_ack = 1'b0;
    check_cnt++;
    if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h0000_4004 || bus.o_mem_be !== 4'b0001)
      $display("FAIL rst_acc1: got req=%b addr=%h be=%b want 1/00004004/0001",
               bus.o_mem_req, bus.o_mem_addr, bus.o_mem_be);
    else pass_cnt++;
    #1 i_rst_n = 1'b0;
    #1;
    check_cnt++;
    if (bus.o_mem_req !== 1'b0 || bus.o_mem_be !== 4'b0 || bus.o_mem_addr !== 32'h0)
      $display("FAIL rst_abort_mem: got req=%b be=%b addr=%h want 0/0000/0",
               bus.o_mem_req, bus.o_mem_be, bus.o_mem_addr);
    else pass_cnt++;
    check_cnt++;
    if (bus.o_ready !== 1'b1 || bus.o_rdata !== 32'h0)
      $display("FAIL rst_abort_core: got ready=%b rdata=%h want 1/0", bus.o_ready, bus.o_rdata);
    else pass_cnt++;
    bus.i_mem_ack = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (bus.o_rsp_valid !== 1'b0 || bus.o_mem_req !== 1'b0 || bus.o_ready !== 1'b1) bad = 1'b1;
    end
    bus.i_mem_ack = 1'b0;
    check_cnt++;
    if (bad !== 1'b0) $display("FAIL rst_late_ack: got activity=%b want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    i_rst_n         = 1'b1;
    bus.i_req       = 1'b0;
    bus.i_we        = 1'b0;
    bus.i_addr      = 32'h0;
    bus.i_wdata     = 32'h0;
    bus.i_size      = 2'b00;
    bus.i_unsigned  = 1'b0;
    bus.i_mem_ack   = 1'b0;
    bus.i_mem_rdata = 32'h0;
    #1 i_rst_n = 1'b0;
    #2;
    test_reset;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    test_lb_high_byte;
    test_lhu_split;
    test_sw_split;
    test_lw_wait;
    test_lh_sign;
    test_back_to_back;
    test_reset_acc1;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
